// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall-bit layout,
// stall patterns, FSM state encoding and the stall priority encoder.
package pipe_ctrl_pkg;

    // Stall vector layout, one hold bit per pipeline stage
    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef logic [STALL_W-1:0] stall_t;

    // A stalling stage holds itself and every stage in front of it
    localparam stall_t STALL_NONE     = 6'b000000;
    localparam stall_t STALL_FROM_IF  = 6'b000011;
    localparam stall_t STALL_FROM_ID  = 6'b000111;
    localparam stall_t STALL_FROM_EX  = 6'b001111;
    localparam stall_t STALL_FROM_MEM = 6'b011111;
    localparam stall_t STALL_ALL      = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // The deepest requesting stage wins: mem > ex > id > if
    function automatic stall_t stall_pattern(input logic req_if,
                                             input logic req_id,
                                             input logic req_ex,
                                             input logic req_mem);
        stall_t pat;
        if (req_mem)      pat = STALL_FROM_MEM;
        else if (req_ex)  pat = STALL_FROM_EX;
        else if (req_id)  pat = STALL_FROM_ID;
        else if (req_if)  pat = STALL_FROM_IF;
        else              pat = STALL_NONE;
        return pat;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// The master side raises requests; the slave side (pipe_ctrl) answers.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    // Requests from the pipeline and debug unit
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic             dbg_halt_req;
    logic             dbg_resume;

    // Control back to the pipeline plus status
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             dbg_halted;
    logic             wdog_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output flush_req, flush_pc, dbg_halt_req, dbg_resume,
        input  stall, flush, new_pc, dbg_halted, wdog_err,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  flush_req, flush_pc, dbg_halt_req, dbg_resume,
        output stall, flush, new_pc, dbg_halted, wdog_err,
        output stall_cycles, flush_count
    );

endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky
// error once the count has reached WDOG_LIMIT. Frozen while halted.
module pipe_ctrl_wdog #(
    parameter int WDOG_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_any_i,
    input  logic flush_i,
    input  logic halted_i,
    output logic wdog_err_o
);

    localparam int            CW    = (WDOG_LIMIT < 1) ? 1 : $clog2(WDOG_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WDOG_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Next count: clear on any free or flushed cycle, saturate at the limit
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | (cnt_q == LIMIT);
        if (!halted_i) begin
            if (flush_i || !stall_any_i) begin
                cnt_d = '0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign wdog_err_o = err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: encodes per-stage stall requests into hold
// signals, handles flush/redirect, sequences debug halt (drain, then freeze)
// and keeps stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    stall_t           stall_c;
    logic             flush_c;
    logic [31:0]      new_pc_c;
    logic             halted_c;
    logic             stall_any_c;
    logic             wdog_err;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values, independent of block ordering.
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // FSM next state: halt request drains the pipe, then freezes it
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_d
        // unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.dbg_halt_req && !bus.flush_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.dbg_halt_req) begin
                    state_d = ST_RUN;
                end else if (!bus.flush_req && !bus.stallreq_ex && !bus.stallreq_mem) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (bus.dbg_resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: stall/flush/redirect; a flush needs the PC free to load
    // the target, so it clears the stall vector even while draining
    always_comb begin
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = '0;
        if (!rst) begin
            case (state_q)
                ST_HALTED: begin
                    stall_c = STALL_ALL;
                end
                default: begin
                    if (bus.flush_req) begin
                        flush_c  = 1'b1;
                        new_pc_c = bus.flush_pc;
                    end else begin
                        stall_c = stall_pattern(bus.stallreq_if, bus.stallreq_id,
                                                bus.stallreq_ex, bus.stallreq_mem);
                        if (state_q == ST_DRAIN) stall_c = stall_c | STALL_FROM_IF;
                    end
                end
            endcase
        end
    end

    assign halted_c    = (state_q == ST_HALTED);
    assign stall_any_c = (stall_c != STALL_NONE);

    // Performance counters, wrapping at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_c[STALL_PC] == STOP && !halted_c) stall_cycles_q <= stall_cycles_q + 1'b1;
            if (flush_c)                                flush_count_q  <= flush_count_q + 1'b1;
        end
    end

    pipe_ctrl_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk         (clk),
        .rst         (rst),
        .stall_any_i (stall_any_c),
        .flush_i     (flush_c),
        .halted_i    (halted_c),
        .wdog_err_o  (wdog_err)
    );

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_c;
    assign bus.new_pc       = new_pc_c;
    assign bus.dbg_halted   = halted_c;
    assign bus.wdog_err     = wdog_err;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;

endmodule
